// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit CLA slice.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 used at elaboration to size the nibble counter.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle; NIBBLE_SERIAL_SUB_EN adds the sub request bit.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef NIBBLE_SERIAL_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g  = a & b;
  assign p  = a ^ b;

  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
  assign c4 = gg | (gp & c0);

  assign s  = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle through a 4-bit CLA slice.
// Build with NIBBLE_SERIAL_SUB_EN to add a subtract request (sum = a - b).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = clog2(NIBS);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NIB_W-1:0]   slice_s;
  logic               slice_c4;
  logic               slice_gg_unused;
  logic               slice_gp_unused;

  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               last_nib;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming cin is overridden.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub | bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  assign last_nib = (cnt_q == CNT_W'(NIBS - 1));

  cla4_slice u_slice (
    .a  (a_sh[NIB_W-1:0]),
    .b  (b_sh[NIB_W-1:0]),
    .c0 (carry_q),
    .s  (slice_s),
    .c4 (slice_c4),
    .gg (slice_gg_unused),
    .gp (slice_gp_unused)
  );

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = CALC;
      CALC:    if (last_nib) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the datapath registers are ordinary flops, so clearing them in reset is cheap and makes sum/cout/ovf read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.a;
            b_sh    <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          a_sh    <= a_sh >> NIB_W;
          b_sh    <= b_sh >> NIB_W;
          sum_sh  <= {slice_s, sum_sh[WIDTH-1:NIB_W]};
          carry_q <= slice_c4;
          cnt_q   <= cnt_q + 1'b1;
          // Carry into the MSB differs from carry out of it exactly on signed overflow.
          if (last_nib) ovf_q <= a_sh[NIB_W-1] ^ b_sh[NIB_W-1] ^ slice_s[NIB_W-1] ^ slice_c4;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_sh;
  assign bus.cout      = carry_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int WIDTH = 32;
  localparam int NIBS  = WIDTH / 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      s    = full[WIDTH-1:0];
      co   = (a >= b);
      ov   = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      s    = full[WIDTH-1:0];
      co   = full[WIDTH];
      ov   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
    return {ov, co, s};
  endfunction

  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub, input string name);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready wait: got %b want 1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub      = sub;
`endif
    tick();
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cin      = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub      = 1'($urandom);
`endif
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != NIBS) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, n, NIBS);
    end
  endtask

  task automatic compare_result(input logic [WIDTH+1:0] exp, input string name);
    total++;
    if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
      bad++;
      $display("FAIL %s result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
               name, bus.ovf, bus.cout, bus.sum, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
    end
  endtask

  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input string name);
    accept_op(a, b, cin, sub, name);
    wait_result(name);
    compare_result(model(a, b, cin, sub), name);
    release_result(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
  endtask

  task automatic test_directed();
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, "small_add");
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "full_ripple");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "signed_ovf");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "neg_ovf");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             c;
      a = $urandom;
      b = $urandom;
      c = 1'($urandom);
      accept_op(a, b, c, 1'b0, "random");
      wait_result("random");
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      compare_result(model(a, b, c, 1'b0), "random_held");
      release_result("random");
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH+1:0] exp;
    exp = model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    accept_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, "bp");
    wait_result("bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1 || i == 3);
      bus.a        = 32'h0000_00AA;
      bus.b        = 32'h0000_0055;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: got out_valid=%b in_ready=%b sum=%h want 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.sum, exp[WIDTH-1:0]);
      end
    end
    bus.in_valid = 1'b0;
    release_result("bp");
    tick();
    total++;
    if (bus.sum !== exp[WIDTH-1:0] || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_idle_hold: got sum=%h in_ready=%b want %h 1", bus.sum, bus.in_ready, exp[WIDTH-1:0]);
    end
  endtask

  task automatic test_reset_abort();
    accept_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "abort");
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got in_ready=%b out_valid=%b sum=%h cout=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout);
    end
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH+1:0] exp_q[$];
    int               results;
    int               last_cycle;
    int               cycle;
    results       = 0;
    last_cycle    = -1;
    cycle         = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.cin       = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub       = 1'b0;
`endif
    while (results < 5 && cycle < 200) begin
      logic accepting;
      accepting = (bus.in_ready === 1'b1);
      if (accepting) exp_q.push_back(model(bus.a, bus.b, bus.cin, 1'b0));
      if (bus.out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b spurious result: got sum=%h want none", bus.sum);
        end else begin
          logic [WIDTH+1:0] exp;
          exp = exp_q.pop_front();
          if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
            bad++;
            $display("FAIL b2b result: got %h want %h", {bus.ovf, bus.cout, bus.sum}, exp);
          end
        end
        if (last_cycle >= 0) begin
          total++;
          if (cycle - last_cycle != NIBS + 2) begin
            bad++;
            $display("FAIL b2b spacing: got %0d want %0d", cycle - last_cycle, NIBS + 2);
          end
        end
        last_cycle = cycle;
        results++;
      end
      tick();
      cycle++;
      if (accepting) begin
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.cin = 1'($urandom);
      end
    end
    total++;
    if (results != 5) begin
      bad++;
      $display("FAIL b2b count: got %0d want 5", results);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    // Drain any operation started on the final cycle.
    for (int i = 0; i < 2 * NIBS; i++) begin
      if (bus.out_valid === 1'b1) begin
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

`ifdef NIBBLE_SERIAL_SUB_EN
  task automatic test_sub();
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, "sub_neg");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "sub_ovf");
    run_op(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, "sub_zero");
    for (int i = 0; i < 10; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), "sub_random");
    end
  endtask
`endif

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub       = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef NIBBLE_SERIAL_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
